// File: rtl/riscv_mem_pkg.sv
// Shared types and constants for the two-port (instruction/data) memory arbiter.
package riscv_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  localparam int DEFAULT_TIMEOUT = 16;
  // Wait counter is wide enough for the largest allowed TIMEOUT (255).
  localparam int WAIT_W = 8;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick: a lone request wins, a tie goes to the port not granted last.
module rr_arbiter2
  import riscv_mem_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = req;
    if (&req) begin
      gnt = (last_grant == PORT_D) ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/riscv_mem_arbiter.sv
// Shares one memory port between an instruction and a data requester.
// IDLE issues a registered access, BUSY waits for mem_ready or timeout, RESP pulses ack.
module riscv_mem_arbiter
  import riscv_mem_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_ack,
  output logic [DW-1:0] i_rdata,
  output logic          i_err,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  input  logic [3:0]    d_be,
  output logic          d_ack,
  output logic [DW-1:0] d_rdata,
  output logic          d_err,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic [3:0]    mem_be,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready
);

  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  state_e              state_q;
  logic [WAIT_W-1:0]   wait_q;
  logic                last_grant_q;
  logic                winner_q;
  logic                mem_en_q, mem_we_q;
  logic [AW-1:0]       mem_addr_q;
  logic [DW-1:0]       mem_wdata_q;
  logic [3:0]          mem_be_q;
  logic                i_ack_q, i_err_q, d_ack_q, d_err_q;
  logic [DW-1:0]       i_rdata_q, d_rdata_q;
  logic [1:0]          gnt;
  logic                done;

  rr_arbiter2 u_rr (
    .req        ({d_req, i_req}),
    .last_grant (last_grant_q),
    .gnt        (gnt)
  );

  // Ready wins over a coincident timeout, so it alone decides err and data.
  assign done = mem_ready || (wait_q == WAIT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      wait_q       <= '0;
      last_grant_q <= PORT_D;
      winner_q     <= PORT_I;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_be_q     <= '0;
      i_ack_q      <= 1'b0;
      i_err_q      <= 1'b0;
      i_rdata_q    <= '0;
      d_ack_q      <= 1'b0;
      d_err_q      <= 1'b0;
      d_rdata_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|gnt) begin
            state_q      <= BUSY;
            mem_en_q     <= 1'b1;
            wait_q       <= '0;
            winner_q     <= gnt[1];
            last_grant_q <= gnt[1];
            if (gnt[1]) begin
              mem_we_q    <= d_we;
              mem_addr_q  <= d_addr;
              mem_wdata_q <= d_wdata;
              mem_be_q    <= d_be;
            end else begin
              mem_we_q    <= 1'b0;
              mem_addr_q  <= i_addr;
              mem_wdata_q <= '0;
              mem_be_q    <= 4'hF;
            end
          end
        end
        BUSY: begin
          if (done) begin
            state_q  <= RESP;
            mem_en_q <= 1'b0;
            if (winner_q == PORT_D) begin
              d_ack_q   <= 1'b1;
              d_err_q   <= ~mem_ready;
              d_rdata_q <= mem_ready ? mem_rdata : '0;
            end else begin
              i_ack_q   <= 1'b1;
              i_err_q   <= ~mem_ready;
              i_rdata_q <= mem_ready ? mem_rdata : '0;
            end
          end else begin
            wait_q <= wait_q + 1'b1;
          end
        end
        RESP: begin
          state_q <= IDLE;
          i_ack_q <= 1'b0;
          i_err_q <= 1'b0;
          d_ack_q <= 1'b0;
          d_err_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;
  assign i_ack     = i_ack_q;
  assign i_err     = i_err_q;
  assign i_rdata   = i_rdata_q;
  assign d_ack     = d_ack_q;
  assign d_err     = d_err_q;
  assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Directed and randomized bench for riscv_mem_arbiter against a transaction-level model.
module tb_riscv_mem_arbiter;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, d_req, d_we, mem_ready;
  logic [31:0] i_addr, d_addr, d_wdata, mem_rdata;
  logic [3:0]  d_be;
  logic        i_ack, i_err, d_ack, d_err, mem_en, mem_we;
  logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_be;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference state: who was granted last and what each port last received.
  logic        model_last;
  logic [31:0] model_i_rdata, model_d_rdata;

  riscv_mem_arbiter #(.AW(32), .DW(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata), .i_err(i_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_mem_en"}, {31'b0, mem_en}, 32'd0);
    chk({tag, "_mem_we"}, {31'b0, mem_we}, 32'd0);
    chk({tag, "_mem_addr"}, mem_addr, 32'd0);
    chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    chk({tag, "_mem_be"}, {28'b0, mem_be}, 32'd0);
    chk({tag, "_acks"}, {30'b0, i_ack, d_ack}, 32'd0);
    chk({tag, "_errs"}, {30'b0, i_err, d_err}, 32'd0);
    chk({tag, "_i_rdata"}, i_rdata, 32'd0);
    chk({tag, "_d_rdata"}, d_rdata, 32'd0);
  endtask

  task automatic model_reset();
    model_last    = 1'b1;  // data port, so instruction wins the first tie
    model_i_rdata = '0;
    model_d_rdata = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; i_req = 0; d_req = 0; d_we = 0; mem_ready = 0;
    i_addr = '0; d_addr = '0; d_wdata = '0; d_be = '0; mem_rdata = '0;
    @(negedge clk);
    @(negedge clk);
    model_reset();
    chk_reset_outputs("reset");
    rst = 1'b0;
    $display("txn reset applied at cycle %0d", cyc);
  endtask

  // Drives one transaction starting at an IDLE-cycle negedge; lat = BUSY cycles
  // without ready before ready is raised (lat >= TO means ready never comes).
  task automatic run_txn(input logic ireq, input logic dreq, input logic dwe,
                         input logic [31:0] iaddr, input logic [31:0] daddr,
                         input logic [31:0] dwdata, input logic [3:0] dbe,
                         input int lat, input logic [31:0] rdat, output int ack_cyc);
    logic        win, exp_err;
    logic [31:0] e_addr, exp_rd;
    logic        e_we;
    logic [3:0]  e_be;
    int          start;
    if (ireq && !dreq)      win = 1'b0;
    else if (dreq && !ireq) win = 1'b1;
    else                    win = ~model_last;
    model_last = win;
    e_addr  = win ? daddr : iaddr;
    e_we    = win ? dwe : 1'b0;
    e_be    = win ? dbe : 4'hF;
    exp_err = (lat >= TO);
    exp_rd  = exp_err ? 32'd0 : rdat;

    i_req = ireq; d_req = dreq; d_we = dwe; i_addr = iaddr; d_addr = daddr;
    d_wdata = dwdata; d_be = dbe; mem_ready = 0;
    start = cyc;
    @(negedge clk);
    for (int c = 1; c <= TO; c++) begin
      chk("busy_mem_en", {31'b0, mem_en}, 32'd1);
      chk("busy_addr", mem_addr, e_addr);
      chk("busy_we", {31'b0, mem_we}, {31'b0, e_we});
      chk("busy_be", {28'b0, mem_be}, {28'b0, e_be});
      if (win) chk("busy_wdata", mem_wdata, dwdata);
      chk("busy_no_ack", {30'b0, i_ack, d_ack}, 32'd0);
      if (c == 1) begin
        i_addr = $urandom; d_addr = $urandom; d_wdata = $urandom;
        d_be = 4'($urandom); d_we = ~dwe;
      end
      if (c == lat + 1) begin
        mem_ready = 1'b1; mem_rdata = rdat;
      end else begin
        mem_ready = 1'b0; mem_rdata = $urandom;
      end
      @(negedge clk);
      if (c == lat + 1 || c == TO) break;
    end
    mem_ready = 1'b0;
    if (win) model_d_rdata = exp_rd; else model_i_rdata = exp_rd;
    ack_cyc = cyc;

    chk("resp_mem_en", {31'b0, mem_en}, 32'd0);
    chk("resp_acks", {30'b0, i_ack, d_ack}, {30'b0, ~win, win});
    chk("resp_errs", {30'b0, i_err, d_err}, {30'b0, ~win & exp_err, win & exp_err});
    chk("resp_i_rdata", i_rdata, model_i_rdata);
    chk("resp_d_rdata", d_rdata, model_d_rdata);
    chk("resp_latency", 32'(cyc - start), exp_err ? 32'(TO + 1) : 32'(lat + 2));
    $display("txn port=%s we=%0d addr=0x%08h lat=%0d err=%0d rdata=0x%08h ack_cycle=%0d",
             win ? "D" : "I", e_we, e_addr, lat, exp_err, exp_rd, ack_cyc);

    @(negedge clk);
    chk("idle_acks", {30'b0, i_ack, d_ack}, 32'd0);
    chk("idle_mem_en", {31'b0, mem_en}, 32'd0);
    chk("hold_i_rdata", i_rdata, model_i_rdata);
    chk("hold_d_rdata", d_rdata, model_d_rdata);
  endtask

  task automatic idle_cycles(input int n);
    i_req = 0; d_req = 0;
    for (int k = 0; k < n; k++) begin
      mem_ready = 1'($urandom);
      @(negedge clk);
      chk("gap_mem_en", {31'b0, mem_en}, 32'd0);
      chk("gap_acks", {30'b0, i_ack, d_ack}, 32'd0);
    end
    mem_ready = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          a, prev;
    logic [1:0]  r;
    rst = 1'b1;
    do_reset();

    run_txn(1, 0, 0, 32'h8000_0000, 32'h0, 32'h0, 4'h0, 0, 32'h0050_0093, a);
    run_txn(0, 1, 1, 32'h0, 32'h0000_0100, 32'hDEAD_BEEF, 4'b0011, 3, 32'h1234_5678, a);

    do_reset();
    prev = 0;
    for (int k = 0; k < 4; k++) begin
      run_txn(1, 1, 1, 32'h8000_0000 + 32'(4 * k), 32'h200 + 32'(4 * k),
              32'hA5A5_0000 + 32'(k), 4'hC, 0, 32'hC0DE_0000 + 32'(k), a);
      if (k > 0) chk("b2b_spacing", 32'(a - prev), 32'd3);
      prev = a;
    end

    run_txn(0, 1, 0, 32'h0, 32'h0000_0400, 32'h0, 4'hF, TO + 10, 32'hFFFF_FFFF, a);

    // Reset in the middle of a wait: nothing must complete.
    i_req = 0; d_req = 1; d_we = 1; d_addr = 32'h44; d_wdata = 32'h5555_AAAA; d_be = 4'hF;
    @(negedge clk);
    chk("rbusy_mem_en", {31'b0, mem_en}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; d_req = 0;
    model_reset();
    chk_reset_outputs("rbusy");
    $display("txn reset during BUSY at cycle %0d", cyc);
    idle_cycles(3);
    run_txn(0, 1, 0, 32'h0, 32'h0000_0048, 32'h0, 4'hF, 1, 32'h0BAD_F00D, a);

    run_txn(1, 0, 0, 32'h8000_0010, 32'h0, 32'h0, 4'h0, TO - 1, 32'h1357_9BDF, a);

    for (int k = 0; k < 40; k++) begin
      r = 2'($urandom_range(1, 3));
      run_txn(r[0], r[1], 1'($urandom), $urandom, $urandom, $urandom, 4'($urandom),
              int'($urandom_range(0, TO + 2)), $urandom, a);
      if ($urandom_range(0, 3) == 0) idle_cycles(int'($urandom_range(1, 3)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/riscv_mem_arbiter.md
RISCV_MEM_ARBITER -- requirements
Module: riscv_mem_arbiter

Interface
REQ-001 The block SHALL take these parameters (name, default, meaning):
- AW, 32, address width.
- DW, 32, data width.
- TIMEOUT, 16, maximum wait cycles for mem_ready; range 1..255.

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, single clock; all state updates on the rising edge.
- rst, in, 1, reset; synchronous and active-high.
- i_req, in, 1, instruction-port request.
- i_addr, in, AW, instruction-port address.
- i_ack, out, 1, instruction-port completion pulse.
- i_rdata, out, DW, instruction-port read data.
- i_err, out, 1, instruction-port timeout flag, valid with i_ack.
- d_req, in, 1, data-port request.
- d_we, in, 1, data-port write enable (1 = write).
- d_addr, in, AW, data-port address.
- d_wdata, in, DW, data-port write data.
- d_be, in, 4, data-port byte enables.
- d_ack, out, 1, data-port completion pulse.
- d_rdata, out, DW, data-port read data.
- d_err, out, 1, data-port timeout flag, valid with d_ack.
- mem_en, out, 1, shared memory access strobe.
- mem_we, out, 1, shared memory write enable.
- mem_addr, out, AW, shared memory address.
- mem_wdata, out, DW, shared memory write data.
- mem_be, out, 4, shared memory byte enables.
- mem_rdata, in, DW, shared memory read data.
- mem_ready, in, 1, memory completion; sampled only while mem_en=1.

Function
REQ-003 The block SHALL implement a three-state FSM, IDLE -> BUSY -> RESP -> IDLE, with no other transitions except reset.
REQ-004 In IDLE with at least one request high, the block SHALL choose a winner, register its address, we, wdata and be onto the mem_* outputs, set mem_en=1 and move to BUSY on the same edge.
REQ-005 Winner selection SHALL follow these rules:
- If only one request is high, that port wins.
- If both are high, the port not granted last wins.
- last_grant SHALL update only when a transaction is issued.
REQ-006 The instruction port SHALL always drive mem_we=0 and mem_be=4'hF.
REQ-007 In BUSY, the mem_* outputs SHALL hold stable and mem_en SHALL stay 1 until mem_ready=1 is sampled.
REQ-008 When mem_ready=1 is sampled in BUSY, the block SHALL clear mem_en, register mem_rdata into the winner's rdata, set the winner's ack=1 and err=0, and move to RESP.
REQ-009 In BUSY, a wait counter SHALL increment each cycle without mem_ready.
REQ-010 When the wait counter reaches TIMEOUT, the block SHALL clear mem_en, set the winner's ack=1, err=1 and rdata=0, and move to RESP.
REQ-011 If mem_ready and the timeout coincide, mem_ready SHALL take precedence (err=0).
REQ-012 In RESP, exactly one ack SHALL be high for exactly one cycle, and no new request SHALL be sampled; the FSM returns to IDLE on the next edge.
REQ-013 With zero-wait memory (mem_ready=1 in the first BUSY cycle), a request sampled at edge N SHALL produce ack high in the cycle after edge N+1; back-to-back throughput is one transaction per 3 cycles.
REQ-014 Requesters SHALL hold req and their payload stable until ack; changes to a granted payload after grant SHALL be ignored.
REQ-015 A request held high through ack SHALL be treated as a new transaction in the next IDLE cycle.
REQ-016 i_rdata and d_rdata SHALL hold their last value until that port's next ack.
REQ-017 ack SHALL never be asserted in IDLE or BUSY.

Reset
REQ-018 When rst=1 at a rising edge, the block SHALL apply these values:
- State = IDLE.
- mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_be=0.
- All ack, err and rdata outputs = 0.
- Wait counter = 0.
- last_grant = data port, so the instruction port wins the first tie.
REQ-019 A reset during BUSY or RESP SHALL abandon the transaction: no ack is generated and mem_en is low in the first cycle after reset.

Structure
REQ-020 Package riscv_mem_pkg SHALL hold the following, and the block SHALL import it:
- FSM state encoding (IDLE, BUSY, RESP).
- Port ID constants (PORT_I=0, PORT_D=1).
- Default TIMEOUT.
REQ-021 Two-way round-robin selection SHALL be a sub-module rr_arbiter2 with the following interface:
- Inputs: req[1:0], last_grant.
- Output: one-hot gnt[1:0].
- Behaviour: combinational.
REQ-022 The implementation SHALL be 120-400 lines of RTL with a single clock domain.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- Single read: i_req=1, i_addr=0x80000000, memory returns 0x00500093 with zero wait -> mem_en for exactly 1 cycle with mem_addr=0x80000000, then i_ack=1 for 1 cycle with i_rdata=0x00500093 and i_err=0.
- Write with waits: d_req=1, d_we=1, d_addr=0x100, d_wdata=0xDEADBEEF, d_be=4'b0011, mem_ready after 3 cycles -> mem_* stable for 4 cycles, then d_ack=1 for 1 cycle.
- Tie after reset: i_req=d_req=1 held for 4 transactions -> grants I, D, I, D.
- Timeout: d_req=1, mem_ready never asserted, TIMEOUT=16 -> after 16 BUSY cycles mem_en=0, d_ack=1, d_err=1, d_rdata=0.
- Reset in BUSY: rst=1 for 1 cycle mid-wait -> no ack; all outputs at reset values; a fresh request afterwards completes normally.
- Coincident ready and timeout: mem_ready=1 on the TIMEOUT cycle -> ack with err=0 and captured data.
